// File: rtl/qsof_pkg.sv
// Shared definitions for the gate-core amplitude stream receivers.
//   AMP_WIDTH_DEF / N_QUBIT_DEF : default amplitude width and qubit count
//   collector_state_e           : state-vector collector FSM encoding
//   amp_pair_t                  : one complex amplitude (real, imaginary) at default width
package qsof_pkg;

    localparam int AMP_WIDTH_DEF = 32;
    localparam int N_QUBIT_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_e;

    typedef struct packed {
        logic signed [AMP_WIDTH_DEF-1:0] re;
        logic signed [AMP_WIDTH_DEF-1:0] im;
    } amp_pair_t;

endpackage

// File: rtl/statevec_ram.sv
// State-vector storage: DEPTH x WIDTH, one write port, one registered read port.
// A read and a write to the same address on the same edge return the pre-write data.
//   clk     : clock
//   clk_en  : global enable, gates both ports
//   we_i    : write enable      waddr_i : write address    wdata_i : write data
//   re_i    : read enable       raddr_i : read address     rdata_o : registered read data
// Contents are never reset; the owner masks unwritten entries.
module statevec_ram
    import qsof_pkg::*;
#(
    parameter int WIDTH  = 2 * AMP_WIDTH_DEF,
    parameter int ADDR_W = N_QUBIT_DEF
) (
    input  logic              clk,
    input  logic              clk_en,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/statevec_collector.sv
// Collects (state, amplitude) beats from the gate cores into a full state vector.
//   clk, aclr (sync, active-high), clk_en (global hold)
//   start                        : open a new frame (clears occupancy, count, errors)
//   valid_in, state_in, amp_in_* : incoming amplitude beat
//   rd_en, rd_addr               : read request; rd_amp_*/rd_valid one cycle later
//   count                        : distinct basis states written this frame
//   busy / frame_done            : collecting / every basis state written
//   dup_err / stray_err          : sticky beat errors for the current frame
module statevec_collector
    import qsof_pkg::*;
#(
    parameter int AMP_WIDTH = AMP_WIDTH_DEF,
    parameter int N_QUBIT   = N_QUBIT_DEF
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic                        valid_in,
    input  logic signed [AMP_WIDTH-1:0] amp_in_real,
    input  logic signed [AMP_WIDTH-1:0] amp_in_img,
    input  logic        [N_QUBIT-1:0]   state_in,
    input  logic                        rd_en,
    input  logic        [N_QUBIT-1:0]   rd_addr,
    output logic signed [AMP_WIDTH-1:0] rd_amp_real,
    output logic signed [AMP_WIDTH-1:0] rd_amp_img,
    output logic                        rd_valid,
    output logic        [N_QUBIT:0]     count,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        dup_err,
    output logic                        stray_err
);

    localparam int                 DEPTH   = 2 ** N_QUBIT;
    localparam logic [N_QUBIT:0]   DEPTH_C = (N_QUBIT + 1)'(DEPTH);

    collector_state_e   state_q, state_d;
    logic [DEPTH-1:0]   occ_q, occ_d;
    logic [N_QUBIT:0]   count_q, count_d;
    logic               dup_q, dup_d;
    logic               stray_q, stray_d;
    logic               rd_valid_q;
    logic               rd_occ_q;
    logic               we;
    logic [N_QUBIT:0]   count_inc;
    logic [2*AMP_WIDTH-1:0] rdata;

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        count_d = count_q;
        dup_d   = dup_q;
        stray_d = stray_q;
        we      = 1'b0;
        if (start) begin
            // start always wins over a coincident beat, which is dropped silently
            state_d = COLLECT;
            occ_d   = '0;
            count_d = '0;
            dup_d   = 1'b0;
            stray_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (valid_in) begin
                        if (occ_q[state_in]) begin
                            dup_d = 1'b1;
                        end else begin
                            we              = 1'b1;
                            occ_d[state_in] = 1'b1;
                            count_d         = count_inc;
                            if (count_inc == DEPTH_C) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: begin
                    if (valid_in) begin
                        stray_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            count_q    <= '0;
            dup_q      <= 1'b0;
            stray_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_occ_q   <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
            dup_q      <= dup_d;
            stray_q    <= stray_d;
            rd_valid_q <= rd_en;
            // occupancy is sampled pre-write, matching the RAM's read-before-write data
            if (rd_en) begin
                rd_occ_q <= occ_q[rd_addr];
            end
        end
    end

    statevec_ram #(
        .WIDTH  (2 * AMP_WIDTH),
        .ADDR_W (N_QUBIT)
    ) u_ram (
        .clk     (clk),
        .clk_en  (clk_en),
        .we_i    (we & ~aclr),
        .waddr_i (state_in),
        .wdata_i ({amp_in_real, amp_in_img}),
        .re_i    (rd_en & ~aclr),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    // unwritten entries read as zero; the RAM itself is never cleared
    assign rd_amp_real = rd_occ_q ? rdata[2*AMP_WIDTH-1:AMP_WIDTH] : '0;
    assign rd_amp_img  = rd_occ_q ? rdata[AMP_WIDTH-1:0]           : '0;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign busy        = (state_q == COLLECT);
    assign frame_done  = (state_q == DONE);
    assign dup_err     = dup_q;
    assign stray_err   = stray_q;

endmodule

// File: tb/tb_statevec_collector.sv
module tb_statevec_collector;
    import qsof_pkg::*;

    logic               clk = 1'b0;
    logic               aclr, clk_en, start, valid_in, rd_en;
    logic signed [31:0] amp_in_real, amp_in_img;
    logic        [4:0]  state_in, rd_addr;
    logic signed [31:0] rd_amp_real, rd_amp_img;
    logic               rd_valid, busy, frame_done, dup_err, stray_err;
    logic        [5:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    statevec_collector dut (
        .clk(clk), .aclr(aclr), .clk_en(clk_en), .start(start), .valid_in(valid_in),
        .amp_in_real(amp_in_real), .amp_in_img(amp_in_img), .state_in(state_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_amp_real(rd_amp_real), .rd_amp_img(rd_amp_img),
        .rd_valid(rd_valid), .count(count), .busy(busy), .frame_done(frame_done),
        .dup_err(dup_err), .stray_err(stray_err)
    );

    // behavioural reference: a sparse vector of complex amplitudes plus frame status
    amp_pair_t   m_vec [32];
    bit          m_occ [32];
    bit          m_collect, m_done, m_dup, m_stray, m_rdv;
    amp_pair_t   m_rd;

    function automatic int filled();
        int n = 0;
        foreach (m_occ[i]) n += int'(m_occ[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (aclr) begin
            m_collect = 0; m_done = 0; m_dup = 0; m_stray = 0; m_rdv = 0; m_rd = '0;
            foreach (m_occ[i]) m_occ[i] = 0;
        end else if (clk_en) begin
            m_rdv = rd_en;
            if (rd_en) m_rd = m_occ[rd_addr] ? m_vec[rd_addr] : '0;
            if (start) begin
                m_collect = 1; m_done = 0; m_dup = 0; m_stray = 0;
                foreach (m_occ[i]) m_occ[i] = 0;
            end else if (m_collect) begin
                if (valid_in) begin
                    if (m_occ[state_in]) m_dup = 1;
                    else begin
                        m_occ[state_in] = 1;
                        m_vec[state_in] = '{re: amp_in_real, im: amp_in_img};
                        if (filled() == 32) begin m_collect = 0; m_done = 1; end
                    end
                end
            end else if (valid_in) m_stray = 1;
        end
    endtask

    task automatic model_check();
        chk("m_count", 64'(count), 64'(filled()));
        chk("m_busy", 64'(busy), 64'(m_collect));
        chk("m_done", 64'(frame_done), 64'(m_done));
        chk("m_dup", 64'(dup_err), 64'(m_dup));
        chk("m_stray", 64'(stray_err), 64'(m_stray));
        chk("m_rdv", 64'(rd_valid), 64'(m_rdv));
        chk("m_rd", {rd_amp_real, rd_amp_img}, {m_rd.re, m_rd.im});
    endtask

    task automatic cyc(input logic a, input logic ce, input logic st, input logic v,
                       input logic [31:0] re, input logic [31:0] im, input logic [4:0] s,
                       input logic ren, input logic [4:0] ra);
        aclr = a; clk_en = ce; start = st; valid_in = v;
        amp_in_real = re; amp_in_img = im; state_in = s; rd_en = ren; rd_addr = ra;
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle();                  cyc(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();              cyc(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_start();              cyc(0, 1, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic beat(input logic [4:0] s, input logic [31:0] re, input logic [31:0] im);
        cyc(0, 1, 0, 1, re, im, s, 0, 0);
    endtask
    task automatic rd(input logic [4:0] a); cyc(0, 1, 0, 0, 0, 0, 0, 1, a); endtask

    typedef struct {
        logic        start, valid;
        logic [4:0]  st;
        logic [31:0] re, im;
        logic        rd_en;
        logic [4:0]  ra;
        logic [5:0]  e_count;
        logic        e_busy, e_done, e_dup, e_stray, e_rdv;
        logic [31:0] e_rre, e_rim;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // stray, start collision, duplicate, sparse read, same-cycle read-before-write
        tbl[0] = '{0, 1,  3, 32'h1, 32'h1, 0,  0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0};
        tbl[1] = '{1, 1,  3, 32'h1, 32'h1, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0};
        tbl[2] = '{0, 0,  0, 32'h0, 32'h0, 1,  3, 0, 1, 0, 0, 0, 1, 32'h0, 32'h0};
        tbl[3] = '{0, 1,  5, 32'hFFC98E0F, 32'h1234, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0};
        tbl[4] = '{0, 1,  5, 32'h2EFBA141, 32'h5555, 0, 0, 1, 1, 0, 1, 0, 0, 32'h0, 32'h0};
        tbl[5] = '{0, 0,  0, 32'h0, 32'h0, 1,  5, 1, 1, 0, 1, 0, 1, 32'hFFC98E0F, 32'h1234};
        tbl[6] = '{0, 1, 28, 32'hAAAA, 32'hBBBB, 1, 28, 2, 1, 0, 1, 0, 1, 32'h0, 32'h0};
        tbl[7] = '{0, 0,  0, 32'h0, 32'h0, 1,  4, 2, 1, 0, 1, 0, 1, 32'h0, 32'h0};
        tbl[8] = '{0, 0,  0, 32'h0, 32'h0, 1, 28, 2, 1, 0, 1, 0, 1, 32'hAAAA, 32'hBBBB};
        tbl[9] = '{0, 0,  0, 32'h0, 32'h0, 0,  0, 2, 1, 0, 1, 0, 0, 32'hAAAA, 32'hBBBB};

        foreach (m_vec[i]) m_vec[i] = '0;

        do_reset();
        chk("rst_all", {count, busy, frame_done, dup_err, stray_err, rd_valid, rd_amp_real, rd_amp_img}, 64'h0);

        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, tbl[i].start, tbl[i].valid, tbl[i].re, tbl[i].im, tbl[i].st, tbl[i].rd_en, tbl[i].ra);
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
            chk($sformatf("tbl%0d_flags", i), {busy, frame_done, dup_err, stray_err, rd_valid},
                {tbl[i].e_busy, tbl[i].e_done, tbl[i].e_dup, tbl[i].e_stray, tbl[i].e_rdv});
            chk($sformatf("tbl%0d_rd", i), {rd_amp_real, rd_amp_img}, {tbl[i].e_rre, tbl[i].e_rim});
        end

        // full frame, boundary at the last beat
        do_reset();
        do_start();
        for (int s = 0; s < 32; s++) begin
            beat(5'(s), 32'(s * 16), -32'(s));
            if (s == 30) chk("pre_last", {count, busy, frame_done}, {6'd31, 1'b1, 1'b0});
        end
        chk("full_frame", {count, busy, frame_done}, {6'd32, 1'b0, 1'b1});
        rd(7);
        chk("full_rd7", {rd_valid, rd_amp_real, rd_amp_img}, {1'b1, 32'd112, 32'hFFFF_FFF9});
        beat(9, 32'h77, 32'h77);
        chk("done_stray", {count, frame_done, stray_err, dup_err}, {6'd32, 1'b1, 1'b1, 1'b0});
        do_start();
        chk("restart", {count, busy, frame_done, stray_err}, {6'd0, 1'b1, 1'b0, 1'b0});

        // clk_en gating mid-frame
        for (int s = 0; s < 4; s++) beat(5'(s), 32'h100 + 32'(s), 32'h200);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 32'hDEAD, 32'hBEEF, 5'(10 + k), 1, 0);
        chk("gated", {count, rd_valid}, {6'd4, 1'b0});
        beat(20, 32'h8000_0001, 32'h7FFF_FFFF);
        chk("ungated", 64'(count), 64'd5);
        rd(10);
        chk("gated_nowrite", {rd_valid, rd_amp_real, rd_amp_img}, {1'b1, 64'h0});
        rd(20);
        chk("sign_exact", {rd_amp_real, rd_amp_img}, {32'h8000_0001, 32'h7FFF_FFFF});

        // reset mid-frame, then a complete frame
        do_reset();
        do_start();
        for (int s = 0; s < 10; s++) beat(5'(31 - s), 32'(s), 32'(s));
        rd(31);
        do_reset();
        chk("midrst", {count, busy, frame_done, dup_err, stray_err, rd_valid, rd_amp_real, rd_amp_img}, 64'h0);
        do_start();
        for (int s = 0; s < 32; s++) beat(5'(s), $urandom, $urandom);
        chk("post_rst_done", {count, frame_done}, {6'd32, 1'b1});

        // randomized traffic against the reference
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 600) == 0, ($urandom % 8) != 0,
                !m_collect && (($urandom % 6) == 0), ($urandom % 4) != 0,
                $urandom, $urandom, 5'($urandom), ($urandom % 3) == 0, 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
